obi_rsp_buffer: RTL and testbench
=================================

Name: obi_rsp_buffer

Overview:
- OBI manager-to-subordinate shim that limits outstanding transactions to MaxTrans.
- Buffers responses in a MaxTrans-deep FIFO, so a manager using rready backpressure can talk to a subordinate that has no rready (the subordinate must always accept).
- Parametrised successor of the fixed-config OBI definitions: address, data and ID widths and outstanding depth are all generic.
- Sits at any crossbar or subordinate port where UseRReady differs between the two sides.

Parameters:
- AddrWidth, 32, request address width.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.
- IdWidth, 1, transaction ID width (>=1).
- MaxTrans, 2, max outstanding transactions and FIFO depth (>=1; elaboration error otherwise).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- m_req_i  in  1  manager request
- m_gnt_o  out  1  grant to manager
- m_addr_i  in  AddrWidth  address
- m_we_i  in  1  write enable
- m_be_i  in  DataWidth/8  byte enables
- m_wdata_i  in  DataWidth  write data
- m_aid_i  in  IdWidth  request ID
- m_rvalid_o  out  1  response valid to manager
- m_rready_i  in  1  manager response ready
- m_rdata_o  out  DataWidth  read data
- m_rid_o  out  IdWidth  response ID
- m_err_o  out  1  response error
- s_req_o  out  1  request to subordinate
- s_gnt_i  in  1  subordinate grant
- s_addr_o, s_we_o, s_be_o, s_wdata_o, s_aid_o  out  (as manager side)  forwarded request fields
- s_rvalid_i  in  1  subordinate response valid (no rready)
- s_rdata_i  in  DataWidth  response data
- s_rid_i  in  IdWidth  response ID
- s_err_i  in  1  response error
- outstanding_o  out  $clog2(MaxTrans+1)  current credit count
- protocol_err_o  out  1  sticky unexpected-response flag

Behaviour:
- Single clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: outstanding_o=0, FIFO empty, m_rvalid_o=0, protocol_err_o=0.
- While rst_i=1, s_req_o=0 and m_gnt_o=0 regardless of inputs.
- Request path is combinational, zero latency. Request fields are forwarded unchanged.
  - credit_ok = (cnt < MaxTrans).
  - s_req_o = m_req_i & credit_ok.
  - m_gnt_o = s_gnt_i & credit_ok.
- Credit counter cnt (drives outstanding_o):
  - +1 on s_req_o & s_gnt_i.
  - -1 on m_rvalid_o & m_rready_i.
  - Both in the same cycle: unchanged.
  - Never wraps. At cnt==MaxTrans the request is blocked; the manager must hold req and fields stable per OBI.
- Response FIFO, depth MaxTrans, entry = {err, rid, rdata}:
  - Push on s_rvalid_i (subject to the bypass rule under Optional Feature).
  - Pop on m_rvalid_o & m_rready_i.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - First-word-fall-through: head entry drives m_rdata_o/m_rid_o/m_err_o.
  - m_rvalid_o = FIFO not empty.
  - Order preserved; responses are not reordered by ID.
- Default latency: s_rvalid_i in cycle N gives m_rvalid_o in cycle N+1.
- Credits guarantee no overflow. If s_rvalid_i arrives while the FIFO is full with no pop:
  - Response is dropped.
  - protocol_err_o is set and stays 1 until reset.
  - cnt is unaffected.
- m_rready_i=0 with m_rvalid_o=1: head data held stable until accepted.
- Reset mid-operation: all outstanding state is discarded; responses arriving in the cycle rst_i is high are ignored.

Optional Feature:
- Macro OBI_RSP_BUFFER_BYPASS_EN.
- Defined: when the FIFO is empty and s_rvalid_i=1:
  - m_rvalid_o=1 and the s_r* fields drive the m_r* outputs in the same cycle (zero latency).
  - If m_rready_i=1 the response is consumed and not pushed; otherwise it is pushed.
  - Counter decrements apply to bypassed accepts.
- Undefined: every response passes through the FIFO with fixed 1-cycle latency; no s_r* to m_r* combinational path.

Test Plan:
- Reset: assert rst_i 2 cycles with m_req_i=1, s_gnt_i=1 -> s_req_o=0, m_gnt_o=0, m_rvalid_o=0, outstanding_o=0; first cycle after release: s_req_o=1, m_gnt_o=1.
- Credit limit, MaxTrans=2, m_rready_i=0: issue 3 requests with s_gnt_i=1 -> first two granted, outstanding_o=2, third held with m_gnt_o=0 and s_req_o=0 until one response is accepted, then granted next cycle.
- Backpressure: 2 responses (rid 0 data 0xA5A5A5A5, rid 1 data 0x5A5A5A5A) arrive back-to-back with m_rready_i=0 -> both buffered, m_rdata_o stable at 0xA5A5A5A5; raise m_rready_i -> delivered in order over 2 cycles, outstanding_o returns to 0.
- Simultaneous: grant new request, accept response, and receive a response in the same cycle with FIFO full -> outstanding_o unchanged, occupancy unchanged, no protocol_err_o.
- Protocol error: inject s_rvalid_i with FIFO full and m_rready_i=0 -> response dropped, protocol_err_o=1 and held until rst_i.
- Latency: s_rvalid_i with s_err_i=1, m_rready_i=1, FIFO empty -> m_rvalid_o=1 and m_err_o=1 in the same cycle with OBI_RSP_BUFFER_BYPASS_EN defined, next cycle without it.

Source files
------------

// File: rtl/obi_rsp_buffer.sv
// rtl/obi_rsp_buffer.sv - OBI credit limiter with MaxTrans-deep response FIFO for rready-less subordinates.
// Define OBI_RSP_BUFFER_BYPASS_EN for a zero-latency path when the FIFO is empty.
module obi_rsp_buffer #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int IdWidth   = 1,
   parameter int MaxTrans  = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           m_req_i,
   output logic                           m_gnt_o,
   input  logic [AddrWidth-1:0]           m_addr_i,
   input  logic                           m_we_i,
   input  logic [DataWidth/8-1:0]         m_be_i,
   input  logic [DataWidth-1:0]           m_wdata_i,
   input  logic [IdWidth-1:0]             m_aid_i,
   output logic                           m_rvalid_o,
   input  logic                           m_rready_i,
   output logic [DataWidth-1:0]           m_rdata_o,
   output logic [IdWidth-1:0]             m_rid_o,
   output logic                           m_err_o,
   output logic                           s_req_o,
   input  logic                           s_gnt_i,
   output logic [AddrWidth-1:0]           s_addr_o,
   output logic                           s_we_o,
   output logic [DataWidth/8-1:0]         s_be_o,
   output logic [DataWidth-1:0]           s_wdata_o,
   output logic [IdWidth-1:0]             s_aid_o,
   input  logic                           s_rvalid_i,
   input  logic [DataWidth-1:0]           s_rdata_i,
   input  logic [IdWidth-1:0]             s_rid_i,
   input  logic                           s_err_i,
   output logic [$clog2(MaxTrans+1)-1:0]  outstanding_o,
   output logic                           protocol_err_o
);

   localparam int CW = $clog2(MaxTrans + 1);
   localparam int PW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
   localparam int EW = 1 + IdWidth + DataWidth;

   generate
      if (MaxTrans < 1) begin : g_bad_max_trans
         $error("obi_rsp_buffer: MaxTrans must be >= 1");
      end
      if (IdWidth < 1) begin : g_bad_id_width
         $error("obi_rsp_buffer: IdWidth must be >= 1");
      end
   endgenerate

   logic [CW-1:0] cnt;
   logic [CW-1:0] occ;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [EW-1:0] mem [MaxTrans];
   logic [EW-1:0] head;
   logic          perr;
   logic          credit_ok;
   logic          empty;
   logic          full;
   logic          rsp_in;
   logic          bypass;
   logic          accept;
   logic          pop;
   logic          push;
   logic          drop;
   logic          inc;
   logic          dec;

   assign credit_ok = (cnt < CW'(MaxTrans));
   assign s_req_o   = m_req_i & credit_ok & ~rst_i;
   assign m_gnt_o   = s_gnt_i & credit_ok & ~rst_i;
   assign s_addr_o  = m_addr_i;
   assign s_we_o    = m_we_i;
   assign s_be_o    = m_be_i;
   assign s_wdata_o = m_wdata_i;
   assign s_aid_o   = m_aid_i;

   assign empty  = (occ == '0);
   assign full   = (occ == CW'(MaxTrans));
   assign head   = mem[rd_ptr];
   // Responses seen while in reset belong to discarded transactions.
   assign rsp_in = s_rvalid_i & ~rst_i;

`ifdef OBI_RSP_BUFFER_BYPASS_EN
   assign bypass = empty & rsp_in;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      m_rvalid_o = ~rst_i & (~empty | bypass);
      m_rdata_o  = head[DataWidth-1:0];
      m_rid_o    = head[DataWidth +: IdWidth];
      m_err_o    = head[EW-1];
      if (bypass) begin
         m_rdata_o = s_rdata_i;
         m_rid_o   = s_rid_i;
         m_err_o   = s_err_i;
      end
   end

   assign accept = m_rvalid_o & m_rready_i;
   assign pop    = accept & ~empty;
   assign push   = rsp_in & ~(bypass & m_rready_i) & (~full | pop);
   assign drop   = rsp_in & full & ~pop;
   assign inc    = s_req_o & s_gnt_i;
   assign dec    = accept & (cnt != '0);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= {s_err_i, s_rid_i, s_rdata_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt    <= '0;
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         perr   <= 1'b0;
      end else begin
         if (inc && !dec) begin
            cnt <= cnt + CW'(1);
         end else if (dec && !inc) begin
            cnt <= cnt - CW'(1);
         end

         if (push && !pop) begin
            occ <= occ + CW'(1);
         end else if (pop && !push) begin
            occ <= occ - CW'(1);
         end

         if (push) begin
            wr_ptr <= (wr_ptr == PW'(MaxTrans - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(MaxTrans - 1)) ? '0 : rd_ptr + PW'(1);
         end

         if (drop) begin
            perr <= 1'b1;
         end
      end
   end

   assign outstanding_o  = cnt;
   assign protocol_err_o = perr;

endmodule

// File: tb/tb_obi_rsp_buffer.sv
// tb/tb_obi_rsp_buffer.sv - Table-driven directed bench for obi_rsp_buffer (MaxTrans=2).
// Expectations follow OBI_RSP_BUFFER_BYPASS_EN when the bench is built with it.
module tb_obi_rsp_buffer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        m_req_i;
   logic        m_gnt_o;
   logic [31:0] m_addr_i;
   logic        m_we_i;
   logic [3:0]  m_be_i;
   logic [31:0] m_wdata_i;
   logic [0:0]  m_aid_i;
   logic        m_rvalid_o;
   logic        m_rready_i;
   logic [31:0] m_rdata_o;
   logic [0:0]  m_rid_o;
   logic        m_err_o;
   logic        s_req_o;
   logic        s_gnt_i;
   logic [31:0] s_addr_o;
   logic        s_we_o;
   logic [3:0]  s_be_o;
   logic [31:0] s_wdata_o;
   logic [0:0]  s_aid_o;
   logic        s_rvalid_i;
   logic [31:0] s_rdata_i;
   logic [0:0]  s_rid_i;
   logic        s_err_i;
   logic [1:0]  outstanding_o;
   logic        protocol_err_o;

   always #5 clk = ~clk;

   obi_rsp_buffer #(
      .AddrWidth(32), .DataWidth(32), .IdWidth(1), .MaxTrans(2)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
      .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_aid_i(m_aid_i),
      .m_rvalid_o(m_rvalid_o), .m_rready_i(m_rready_i), .m_rdata_o(m_rdata_o),
      .m_rid_o(m_rid_o), .m_err_o(m_err_o),
      .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_aid_o(s_aid_o),
      .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .s_rid_i(s_rid_i), .s_err_i(s_err_i),
      .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
   );

   typedef struct {
      logic        rst, req, gnt, rdy, rv;
      logic [31:0] rdata;
      logic        rid, err;
      logic        e_sreq, e_mgnt, e_rv;
      logic [31:0] e_rdata;
      logic        e_rid, e_err;
      logic [1:0]  e_out;
      logic        e_perr;
      logic        byp;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, req, gnt, rdy, rv, input logic [31:0] rdata,
                      input logic rid, err, e_sreq, e_mgnt, e_rv, input logic [31:0] e_rdata,
                      input logic e_rid, e_err, input logic [1:0] e_out, input logic e_perr, byp);
      vec_t v;
      v.rst = rst; v.req = req; v.gnt = gnt; v.rdy = rdy; v.rv = rv;
      v.rdata = rdata; v.rid = rid; v.err = err;
      v.e_sreq = e_sreq; v.e_mgnt = e_mgnt; v.e_rv = e_rv; v.e_rdata = e_rdata;
      v.e_rid = e_rid; v.e_err = e_err; v.e_out = e_out; v.e_perr = e_perr; v.byp = byp;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rst, req, gnt, rdy, rv, input logic [31:0] rdata,
                        input logic rid, err);
      rst_i = rst; m_req_i = req; s_gnt_i = gnt; m_rready_i = rdy;
      s_rvalid_i = rv; s_rdata_i = rdata; s_rid_i = rid; s_err_i = err;
   endtask

   initial begin
      m_addr_i = 32'h1000_0040; m_we_i = 1'b1; m_be_i = 4'hC;
      m_wdata_i = 32'hCAFE_F00D; m_aid_i = 1'b1;
      drive(1, 1, 1, 0, 0, 0, 0, 0);

      //   rst req gnt rdy rv  rdata          rid err | sreq mgnt rv  rdata          rid err out perr byp
      add(1, 1, 1, 0, 0, 32'h0,          0, 0,   0, 0, 0, 32'h0,          0, 0, 0, 0, 0);
      add(1, 1, 1, 0, 0, 32'h0,          0, 0,   0, 0, 0, 32'h0,          0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 32'h0,          0, 0,   1, 1, 0, 32'h0,          0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 32'h0,          0, 0,   1, 1, 0, 32'h0,          0, 0, 1, 0, 0);
      add(0, 1, 1, 0, 0, 32'h0,          0, 0,   0, 0, 0, 32'h0,          0, 0, 2, 0, 0);
      add(0, 1, 1, 0, 1, 32'hA5A5A5A5,   0, 0,   0, 0, 0, 32'h0,          0, 0, 2, 0, 1);
      add(0, 1, 1, 0, 1, 32'h5A5A5A5A,   1, 0,   0, 0, 1, 32'hA5A5A5A5,   0, 0, 2, 0, 0);
      add(0, 1, 1, 0, 0, 32'h0,          0, 0,   0, 0, 1, 32'hA5A5A5A5,   0, 0, 2, 0, 0);
      add(0, 1, 1, 1, 0, 32'h0,          0, 0,   0, 0, 1, 32'hA5A5A5A5,   0, 0, 2, 0, 0);
      add(0, 1, 1, 0, 0, 32'h0,          0, 0,   1, 1, 1, 32'h5A5A5A5A,   1, 0, 1, 0, 0);
      add(0, 0, 1, 0, 1, 32'h11111111,   0, 0,   0, 0, 1, 32'h5A5A5A5A,   1, 0, 2, 0, 0);
      add(0, 0, 0, 1, 0, 32'h0,          0, 0,   0, 0, 1, 32'h5A5A5A5A,   1, 0, 2, 0, 0);
      add(0, 0, 0, 0, 1, 32'h22222222,   1, 1,   0, 0, 1, 32'h11111111,   0, 0, 1, 0, 0);
      add(0, 1, 1, 1, 1, 32'h33333333,   0, 0,   1, 1, 1, 32'h11111111,   0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0, 0,   0, 0, 1, 32'h22222222,   1, 1, 1, 0, 0);
      add(0, 0, 0, 0, 1, 32'h44444444,   0, 0,   0, 0, 1, 32'h22222222,   1, 1, 1, 0, 0);
      add(0, 0, 0, 1, 0, 32'h0,          0, 0,   0, 0, 1, 32'h22222222,   1, 1, 1, 1, 0);
      add(0, 0, 0, 1, 0, 32'h0,          0, 0,   0, 0, 1, 32'h33333333,   0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0, 0,   0, 0, 0, 32'h0,          0, 0, 0, 1, 0);
      add(1, 1, 1, 0, 1, 32'h55555555,   0, 0,   0, 0, 0, 32'h0,          0, 0, 0, 1, 0);
      add(0, 0, 0, 0, 0, 32'h0,          0, 0,   0, 0, 0, 32'h0,          0, 0, 0, 0, 0);

      @(posedge clk);
      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
`ifdef OBI_RSP_BUFFER_BYPASS_EN
         if (v.byp) begin
            v.e_rv = 1'b1; v.e_rdata = v.rdata; v.e_rid = v.rid; v.e_err = v.err;
         end
`endif
         @(negedge clk);
         drive(v.rst, v.req, v.gnt, v.rdy, v.rv, v.rdata, v.rid, v.err);
         #1;
         chk($sformatf("v%0d s_req", i), 32'(s_req_o), 32'(v.e_sreq));
         chk($sformatf("v%0d m_gnt", i), 32'(m_gnt_o), 32'(v.e_mgnt));
         chk($sformatf("v%0d m_rvalid", i), 32'(m_rvalid_o), 32'(v.e_rv));
         chk($sformatf("v%0d outstanding", i), 32'(outstanding_o), 32'(v.e_out));
         chk($sformatf("v%0d protocol_err", i), 32'(protocol_err_o), 32'(v.e_perr));
         if (v.e_rv) begin
            chk($sformatf("v%0d m_rdata", i), m_rdata_o, v.e_rdata);
            chk($sformatf("v%0d m_rid", i), 32'(m_rid_o), 32'(v.e_rid));
            chk($sformatf("v%0d m_err", i), 32'(m_err_o), 32'(v.e_err));
         end
      end

      chk("fwd addr", s_addr_o, 32'h1000_0040);
      chk("fwd wdata", s_wdata_o, 32'hCAFE_F00D);
      chk("fwd be_we_aid", {26'd0, s_be_o, s_we_o, s_aid_o}, 32'h33);

      // Latency of an error response into an empty FIFO with rready high
      @(negedge clk);
      drive(0, 1, 1, 0, 0, 32'h0, 0, 0);
      #1;
      chk("lat issue s_req", 32'(s_req_o), 32'd1);
      @(negedge clk);
      drive(0, 0, 0, 1, 1, 32'hDEADBEEF, 1, 1);
      #1;
      chk("lat c0 outstanding", 32'(outstanding_o), 32'd1);
`ifdef OBI_RSP_BUFFER_BYPASS_EN
      chk("lat c0 m_rvalid", 32'(m_rvalid_o), 32'd1);
      chk("lat c0 m_err", 32'(m_err_o), 32'd1);
      chk("lat c0 m_rdata", m_rdata_o, 32'hDEADBEEF);
`else
      chk("lat c0 m_rvalid", 32'(m_rvalid_o), 32'd0);
`endif
      @(negedge clk);
      drive(0, 0, 0, 1, 0, 32'h0, 0, 0);
      #1;
`ifdef OBI_RSP_BUFFER_BYPASS_EN
      chk("lat c1 m_rvalid", 32'(m_rvalid_o), 32'd0);
      chk("lat c1 outstanding", 32'(outstanding_o), 32'd0);
`else
      chk("lat c1 m_rvalid", 32'(m_rvalid_o), 32'd1);
      chk("lat c1 m_err", 32'(m_err_o), 32'd1);
      chk("lat c1 m_rid", 32'(m_rid_o), 32'd1);
      chk("lat c1 m_rdata", m_rdata_o, 32'hDEADBEEF);
      chk("lat c1 outstanding", 32'(outstanding_o), 32'd1);
`endif
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
      #1;
      chk("lat c2 m_rvalid", 32'(m_rvalid_o), 32'd0);
      chk("lat c2 outstanding", 32'(outstanding_o), 32'd0);
      chk("lat c2 protocol_err", 32'(protocol_err_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
